// File: rtl/ms_ftdi_fifo_emu_if.sv
// FT245 synchronous-FIFO pins plus host byte streams for the emulator.
// slave = emulator side, master = bridge/host side.
interface ms_ftdi_fifo_emu_if #(
   parameter int CRxDepthLog2 = 4,
   parameter int CTxDepthLog2 = 4
);
   logic [7:0]            APhyDataO;
   logic [7:0]            APhyDataI;
   logic                  APhyRxfN;
   logic                  APhyTxeN;
   logic                  APhyRdN;
   logic                  APhyWrN;
   logic                  APhyOeN;
   logic                  APhySiwuN;
   logic [7:0]            AHostRxData;
   logic                  AHostRxValid;
   logic                  AHostRxReady;
   logic [7:0]            AHostTxData;
   logic                  AHostTxValid;
   logic                  AHostTxReady;
   logic                  AHostTxFlush;
   logic [CRxDepthLog2:0] ARxCnt;
   logic [CTxDepthLog2:0] ATxCnt;

   modport slave (
      output APhyDataO, APhyRxfN, APhyTxeN, AHostRxReady, AHostTxData, AHostTxValid,
             AHostTxFlush, ARxCnt, ATxCnt,
      input  APhyDataI, APhyRdN, APhyWrN, APhyOeN, APhySiwuN, AHostRxData, AHostRxValid,
             AHostTxReady
   );

   modport master (
      input  APhyDataO, APhyRxfN, APhyTxeN, AHostRxReady, AHostTxData, AHostTxValid,
             AHostTxFlush, ARxCnt, ATxCnt,
      output APhyDataI, APhyRdN, APhyWrN, APhyOeN, APhySiwuN, AHostRxData, AHostRxValid,
             AHostTxReady
   );
endinterface

// File: rtl/ms_ftdi_fifo_emu.sv
// Chip-side FT245 sync-FIFO emulator: RX FIFO (host->bridge) and TX FIFO (bridge->host).
// Optional MS_FTDI_FIFO_EMU_STAT_EN adds AStat byte counters and sticky strobe-error flags.
module ms_ftdi_fifo_emu #(
   parameter int CRxDepthLog2 = 4,
   parameter int CTxDepthLog2 = 4
) (
   input  logic               AClkH,
   input  logic               AResetH,
   input  logic               AClkHEn,
   ms_ftdi_fifo_emu_if.slave  bus
`ifdef MS_FTDI_FIFO_EMU_STAT_EN
   ,
   output logic [31:0]        AStat
`endif
);
   localparam int CRxDepth = 1 << CRxDepthLog2;
   localparam int CTxDepth = 1 << CTxDepthLog2;
   localparam logic [CRxDepthLog2:0] CRxFull = (CRxDepthLog2+1)'(CRxDepth);
   localparam logic [CTxDepthLog2:0] CTxFull = (CTxDepthLog2+1)'(CTxDepth);

   logic [7:0]              rx_mem_q [CRxDepth];
   logic [7:0]              tx_mem_q [CTxDepth];
   logic [CRxDepthLog2-1:0] rx_wr_q, rx_rd_q;
   logic [CTxDepthLog2-1:0] tx_wr_q, tx_rd_q;
   logic [CRxDepthLog2:0]   rx_cnt_q, rx_cnt_d;
   logic [CTxDepthLog2:0]   tx_cnt_q, tx_cnt_d;
   logic                    rxf_q, txe_q, siwu_q, flush_q;
   logic                    rx_push, rx_pop, tx_push, tx_pop;

   always_comb begin
      rx_push = AClkHEn & bus.AHostRxValid & (rx_cnt_q != CRxFull);
      rx_pop  = AClkHEn & ~bus.APhyRdN & ~bus.APhyOeN & ~rxf_q;
      tx_push = AClkHEn & ~bus.APhyWrN & ~txe_q;
      tx_pop  = AClkHEn & bus.AHostTxReady & (tx_cnt_q != '0);

      rx_cnt_d = rx_cnt_q;
      if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + (CRxDepthLog2+1)'(1);
      if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - (CRxDepthLog2+1)'(1);

      tx_cnt_d = tx_cnt_q;
      if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + (CTxDepthLog2+1)'(1);
      if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - (CTxDepthLog2+1)'(1);
   end

   // Storage is not reset; emptiness is carried entirely by the counts.
   always_ff @(posedge AClkH) begin
      if (rx_push) rx_mem_q[rx_wr_q] <= bus.AHostRxData;
      if (tx_push) tx_mem_q[tx_wr_q] <= bus.APhyDataI;
   end

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         rx_cnt_q <= '0;
         tx_cnt_q <= '0;
         rxf_q    <= 1'b1;
         txe_q    <= 1'b0;
         siwu_q   <= 1'b1;
         flush_q  <= 1'b0;
      end else begin
         // Flush is recomputed every cycle so a stalled clock enable cannot stretch it.
         flush_q <= AClkHEn & siwu_q & ~bus.APhySiwuN;
         if (AClkHEn) begin
            if (rx_push) rx_wr_q <= rx_wr_q + CRxDepthLog2'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + CRxDepthLog2'(1);
            if (tx_push) tx_wr_q <= tx_wr_q + CTxDepthLog2'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + CTxDepthLog2'(1);
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            rxf_q    <= (rx_cnt_d == '0);
            txe_q    <= (tx_cnt_d == CTxFull);
            siwu_q   <= bus.APhySiwuN;
         end
      end
   end

   assign bus.APhyDataO    = ~bus.APhyOeN ? rx_mem_q[rx_rd_q] : 8'h00;
   assign bus.APhyRxfN     = rxf_q;
   assign bus.APhyTxeN     = txe_q;
   assign bus.AHostRxReady = (rx_cnt_q != CRxFull);
   assign bus.AHostTxData  = tx_mem_q[tx_rd_q];
   assign bus.AHostTxValid = (tx_cnt_q != '0);
   assign bus.AHostTxFlush = flush_q;
   assign bus.ARxCnt       = rx_cnt_q;
   assign bus.ATxCnt       = tx_cnt_q;

`ifdef MS_FTDI_FIFO_EMU_STAT_EN
   logic [15:0] tx_bytes_q;
   logic [11:0] rx_bytes_q;
   logic        underrun_q, overrun_q;

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         tx_bytes_q <= '0;
         rx_bytes_q <= '0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else if (AClkHEn) begin
         if (tx_push) tx_bytes_q <= tx_bytes_q + 16'd1;
         if (rx_pop)  rx_bytes_q <= rx_bytes_q + 12'd1;
         if (~bus.APhyRdN & ~bus.APhyOeN & rxf_q) underrun_q <= 1'b1;
         if (~bus.APhyWrN & txe_q)                overrun_q  <= 1'b1;
      end
   end

   assign AStat = {2'b00, overrun_q, underrun_q, rx_bytes_q, tx_bytes_q};
`endif
endmodule

// File: tb/tb_ms_ftdi_fifo_emu.sv
// Directed bench for ms_ftdi_fifo_emu with hand-computed expectations.
module tb_ms_ftdi_fifo_emu;
   logic AClkH = 1'b0;
   logic AResetH;
   logic AClkHEn;
   int   tests = 0;
   int   fails = 0;

   ms_ftdi_fifo_emu_if #(.CRxDepthLog2(4), .CTxDepthLog2(4)) bus ();

`ifdef MS_FTDI_FIFO_EMU_STAT_EN
   logic [31:0] AStat;
   ms_ftdi_fifo_emu #(.CRxDepthLog2(4), .CTxDepthLog2(4)) dut (
      .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn), .bus(bus), .AStat(AStat));
`else
   ms_ftdi_fifo_emu #(.CRxDepthLog2(4), .CTxDepthLog2(4)) dut (
      .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn), .bus(bus));
`endif

   always #5 AClkH = ~AClkH;

   task automatic tick();
      @(posedge AClkH);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      AResetH = 1'b1;
      AClkHEn = 1'b1;
      bus.APhyDataI    = 8'h00;
      bus.APhyRdN      = 1'b1;
      bus.APhyWrN      = 1'b1;
      bus.APhyOeN      = 1'b1;
      bus.APhySiwuN    = 1'b1;
      bus.AHostRxData  = 8'h00;
      bus.AHostRxValid = 1'b0;
      bus.AHostTxReady = 1'b0;
      tick();
      tick();
      AResetH = 1'b0;

      chk("rst_rxf",   bus.APhyRxfN, 1);
      chk("rst_txe",   bus.APhyTxeN, 0);
      chk("rst_rdy",   bus.AHostRxReady, 1);
      chk("rst_txv",   bus.AHostTxValid, 0);
      chk("rst_flush", bus.AHostTxFlush, 0);
      chk("rst_dout",  bus.APhyDataO, 0);
      chk("rst_rxcnt", bus.ARxCnt, 0);
      chk("rst_txcnt", bus.ATxCnt, 0);

      // Three host pushes, then a 3-cycle burst read.
      bus.AHostRxValid = 1'b1;
      bus.AHostRxData  = 8'h11;
      tick();
      chk("rxf_after_push1", bus.APhyRxfN, 0);
      bus.AHostRxData = 8'h22;
      tick();
      bus.AHostRxData = 8'h33;
      tick();
      bus.AHostRxValid = 1'b0;
      chk("rxcnt_3", bus.ARxCnt, 3);
      bus.APhyOeN = 1'b0;
      bus.APhyRdN = 1'b0;
      #1;
      chk("rd0", bus.APhyDataO, 8'h11);
      tick();
      chk("rd1", bus.APhyDataO, 8'h22);
      tick();
      chk("rd2", bus.APhyDataO, 8'h33);
      chk("rxf_before_last", bus.APhyRxfN, 0);
      tick();
      chk("rxf_after_last", bus.APhyRxfN, 1);
      chk("rxcnt_0", bus.ARxCnt, 0);
      tick();
      chk("rd_when_empty_ignored", bus.ARxCnt, 0);
      bus.APhyRdN = 1'b1;
      bus.APhyOeN = 1'b1;
      #1;
      chk("dout_oe_high", bus.APhyDataO, 0);

      // Fill RX, attempt overflow, one read, then drain.
      bus.AHostRxValid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.AHostRxData = 8'(8'hA0 + i);
         tick();
      end
      chk("rx_full_rdy", bus.AHostRxReady, 0);
      chk("rx_full_cnt", bus.ARxCnt, 16);
      bus.AHostRxData = 8'hEE;
      tick();
      chk("rx_17th_dropped", bus.ARxCnt, 16);
      bus.AHostRxValid = 1'b0;
      bus.APhyOeN = 1'b0;
      bus.APhyRdN = 1'b0;
      #1;
      chk("rx_full_head", bus.APhyDataO, 8'hA0);
      tick();
      bus.APhyRdN = 1'b1;
      bus.APhyOeN = 1'b1;
      chk("rx_rdy_after_read", bus.AHostRxReady, 1);
      chk("rx_cnt_15", bus.ARxCnt, 15);
      bus.APhyOeN = 1'b0;
      bus.APhyRdN = 1'b0;
      #1;
      for (int i = 1; i < 16; i++) begin
         chk("rx_drain", bus.APhyDataO, 32'(8'hA0 + i));
         tick();
      end
      chk("rx_drain_rxf", bus.APhyRxfN, 1);
      chk("rx_drain_cnt", bus.ARxCnt, 0);
      bus.APhyRdN = 1'b1;
      bus.APhyOeN = 1'b1;

      // Bridge fills TX with host stalled.
      bus.AHostTxReady = 1'b0;
      bus.APhyWrN = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.APhyDataI = 8'(i);
         tick();
      end
      chk("tx_full_txe", bus.APhyTxeN, 1);
      chk("tx_full_cnt", bus.ATxCnt, 16);
      chk("tx_full_valid", bus.AHostTxValid, 1);
      bus.APhyDataI = 8'hFF;
      tick();
      chk("tx_17th_dropped", bus.ATxCnt, 16);

      // WR# at full alongside a host pop: only the pop takes effect.
      bus.APhyDataI = 8'hFE;
      bus.AHostTxReady = 1'b1;
      chk("tx_head0", bus.AHostTxData, 8'h00);
      tick();
      bus.APhyWrN = 1'b1;
      chk("tx_cnt_15", bus.ATxCnt, 15);
      chk("tx_txe_after_pop", bus.APhyTxeN, 0);
      for (int i = 1; i < 16; i++) begin
         chk("tx_pop_order", bus.AHostTxData, 32'(i));
         tick();
      end
      chk("tx_empty_valid", bus.AHostTxValid, 0);
      chk("tx_empty_cnt", bus.ATxCnt, 0);
      bus.AHostTxReady = 1'b0;

      // SIWU# held low for 5 cycles.
      bus.APhySiwuN = 1'b0;
      tick();
      chk("flush_pulse", bus.AHostTxFlush, 1);
      tick();
      chk("flush_one_cycle", bus.AHostTxFlush, 0);
      tick();
      tick();
      tick();
      chk("flush_held_low", bus.AHostTxFlush, 0);
      bus.APhySiwuN = 1'b1;
      tick();
      chk("flush_release", bus.AHostTxFlush, 0);

      // Read strobe while the clock enable is low.
      bus.AHostRxValid = 1'b1;
      bus.AHostRxData  = 8'h5A;
      tick();
      bus.AHostRxValid = 1'b0;
      chk("en_pre_cnt", bus.ARxCnt, 1);
      AClkHEn = 1'b0;
      bus.APhyOeN = 1'b0;
      bus.APhyRdN = 1'b0;
      tick();
      tick();
      chk("en_hold_cnt", bus.ARxCnt, 1);
      chk("en_hold_rxf", bus.APhyRxfN, 0);
      chk("en_hold_data", bus.APhyDataO, 8'h5A);
      bus.APhyRdN = 1'b1;
      bus.APhyOeN = 1'b1;
      AClkHEn = 1'b1;

      // Reset with RX=5 and TX=7.
      bus.AHostRxValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.AHostRxData = 8'(i);
         tick();
      end
      bus.AHostRxValid = 1'b0;
      bus.APhyWrN = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus.APhyDataI = 8'(8'h40 + i);
         tick();
      end
      bus.APhyWrN = 1'b1;
      chk("pre_rst_rx", bus.ARxCnt, 5);
      chk("pre_rst_tx", bus.ATxCnt, 7);
      AResetH = 1'b1;
      tick();
      AResetH = 1'b0;
      chk("mid_rst_rx",  bus.ARxCnt, 0);
      chk("mid_rst_tx",  bus.ATxCnt, 0);
      chk("mid_rst_rxf", bus.APhyRxfN, 1);
      chk("mid_rst_txe", bus.APhyTxeN, 0);
      chk("mid_rst_rdy", bus.AHostRxReady, 1);
      chk("mid_rst_txv", bus.AHostTxValid, 0);

`ifdef MS_FTDI_FIFO_EMU_STAT_EN
      chk("stat_clr", AStat, 0);
      bus.APhyOeN = 1'b0;
      bus.APhyRdN = 1'b0;
      tick();
      bus.APhyRdN = 1'b1;
      bus.APhyOeN = 1'b1;
      chk("stat_underrun", AStat[28], 1);
      chk("stat_rx_bytes", AStat[27:16], 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
